std_edge_event_arbiter: RTL and testbench

- Multi-channel edge-event controller for asynchronous input pins.
- Per channel it synchronises the input, detects the selected edge type, and latches the event as pending.
- A round-robin arbiter shares one valid/ready event port between all channels and reports channel index and edge polarity.
- Sits between raw GPIO/status pins and an interrupt or event-queue consumer.

---
 rtl/std_edge_pkg.sv | 34 +++
 rtl/std_rr_pick.sv | 33 +++
 rtl/std_edge_event_arbiter.sv | 176 +++++++++++++++++
 tb/tb_std_edge_event_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/std_edge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : std_edge_pkg
// Brief    : Shared edge-mode encoding and hit helper for the edge arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package std_edge_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_POS  = 2'b01,
        EDGE_NEG  = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam logic EDGE_FALL = 1'b0;
    localparam logic EDGE_RISE = 1'b1;

    function automatic logic edge_mode_hit(input edge_mode_t mode,
                                           input logic       rise,
                                           input logic       fall);
        logic hit;
        hit = 1'b0;
        case (mode)
            EDGE_POS:  hit = rise;
            EDGE_NEG:  hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/std_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : std_rr_pick
// Brief    : Combinational round-robin picker; first request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module std_rr_pick #(
    parameter  int CH_NUM = 8,
    localparam int IDX_W  = $clog2(CH_NUM)
) (
    input  logic [CH_NUM-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [IDX_W-1:0]  winner_o,
    output logic              any_o
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        w_cand   = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            w_cand = IDX_W'((int'(ptr_i) + i) % CH_NUM);
            if (!any_o && req_i[w_cand]) begin
                any_o    = 1'b1;
                winner_o = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/std_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : std_edge_event_arbiter
// Brief    : Per-channel synchronised edge detection with pending latches,
//            shared through a round-robin valid/ready event port.
// Revision : 1.0 - initial release
// ============================================================================
module std_edge_event_arbiter
    import std_edge_pkg::*;
#(
    parameter  int CH_NUM      = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int IDX_W       = $clog2(CH_NUM)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [CH_NUM-1:0]   i_signal,
    input  logic [CH_NUM-1:0]   i_enable,
    input  logic [2*CH_NUM-1:0] i_mode,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [IDX_W-1:0]    o_channel,
    output logic                o_edge,
    output logic [CH_NUM-1:0]   o_pending,
    output logic [CH_NUM-1:0]   o_overrun,
    input  logic                i_overrun_clr
);

    localparam int                WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0][CH_NUM-1:0] sync_q;
    logic [CH_NUM-1:0]  prev_q;
    logic [WARM_W-1:0]  warm_q;
    logic [CH_NUM-1:0]  hit_q, hit_rise_q;
    logic [CH_NUM-1:0]  pend_q, pend_d;
    logic [CH_NUM-1:0]  ptype_q, ptype_d;
    logic [CH_NUM-1:0]  ovr_q, ovr_d;
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   chan_q, chan_d;
    logic               edge_q, edge_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [CH_NUM-1:0]  w_sync, w_rise, w_fall, w_hit, w_req, w_grant;
    logic               w_warm_done;
    logic               w_load;
    logic               w_any;
    logic [IDX_W-1:0]   w_winner;

    assign w_sync      = sync_q[SYNC_STAGES-1];
    assign w_rise      = w_sync & ~prev_q;
    assign w_fall      = ~w_sync & prev_q;
    assign w_warm_done = (warm_q == WARM_DONE);
    assign w_req       = pend_q & i_enable;

    generate
        for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
            assign w_hit[k]   = w_warm_done & i_enable[k] &
                                edge_mode_hit(edge_mode_t'(i_mode[2*k+1:2*k]),
                                              w_rise[k], w_fall[k]);
            assign w_grant[k] = w_load & (w_winner == IDX_W'(k));
        end
    endgenerate

    // prev_q follows the synchroniser unconditionally so that enabling a
    // channel or changing its mode never manufactures a stale edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_q     <= '0;
            prev_q     <= '0;
            warm_q     <= '0;
            hit_q      <= '0;
            hit_rise_q <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], i_signal};
            prev_q     <= w_sync;
            warm_q     <= w_warm_done ? warm_q : warm_q + WARM_W'(1);
            hit_q      <= w_hit;
            hit_rise_q <= w_rise;
        end
    end

    always_comb begin
        pend_d  = pend_q;
        ptype_d = ptype_q;
        ovr_d   = ovr_q;
        if (i_overrun_clr) begin
            ovr_d = '0;
        end
        for (int k = 0; k < CH_NUM; k++) begin
            if (!i_enable[k]) begin
                pend_d[k] = 1'b0;
            end else if (hit_q[k] && (!pend_q[k] || w_grant[k])) begin
                pend_d[k]  = 1'b1;
                ptype_d[k] = hit_rise_q[k];
            end else if (hit_q[k]) begin
                ovr_d[k] = 1'b1;
            end else if (w_grant[k]) begin
                pend_d[k] = 1'b0;
            end
        end
    end

    std_rr_pick #(
        .CH_NUM   (CH_NUM)
    ) u_rr_pick (
        .req_i    (w_req),
        .ptr_i    (ptr_q),
        .winner_o (w_winner),
        .any_o    (w_any)
    );

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        edge_d  = edge_q;
        ptr_d   = ptr_q;
        w_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    w_load  = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (i_ready) begin
                    if (w_any) begin
                        w_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (w_load) begin
            chan_d = w_winner;
            edge_d = ptype_q[w_winner];
            ptr_d  = (w_winner == IDX_W'(CH_NUM - 1)) ? '0 : w_winner + IDX_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
            edge_q  <= EDGE_FALL;
            ptr_q   <= '0;
            pend_q  <= '0;
            ptype_q <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            edge_q  <= edge_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            ptype_q <= ptype_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_valid   = (state_q == ST_PRESENT);
    assign o_channel = chan_q;
    assign o_edge    = edge_q;
    assign o_pending = pend_q;
    assign o_overrun = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_std_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_std_edge_event_arbiter
// Brief    : Self-checking bench: vector table, scoreboard, corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_std_edge_event_arbiter;

    logic       i_clk;
    logic       i_reset;
    logic [3:0] i_signal;
    logic [3:0] i_enable;
    logic [7:0] i_mode;
    logic       i_ready;
    logic       o_valid;
    logic [1:0] o_channel;
    logic       o_edge;
    logic [3:0] o_pending;
    logic [3:0] o_overrun;
    logic       i_overrun_clr;

    std_edge_event_arbiter #(
        .CH_NUM        (4),
        .SYNC_STAGES   (2)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_signal      (i_signal),
        .i_enable      (i_enable),
        .i_mode        (i_mode),
        .i_ready       (i_ready),
        .o_valid       (o_valid),
        .o_channel     (o_channel),
        .o_edge        (o_edge),
        .o_pending     (o_pending),
        .o_overrun     (o_overrun),
        .i_overrun_clr (i_overrun_clr)
    );

    typedef struct packed {
        logic [1:0] ch;
        logic       edg;
    } ev_t;

    typedef struct {
        int         ch;
        logic [1:0] mode;
        logic       en;
        logic       lvl;
        logic       exp_evt;
    } vec_t;

    ev_t  sb[$];
    vec_t vecs[8];
    int   errors   = 0;
    int   n_checks = 0;
    logic seen;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int ch, input logic e);
        ev_t ev;
        ev.ch  = 2'(ch);
        ev.edg = e;
        sb.push_back(ev);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge i_clk);
            if (o_valid) got = 1'b1;
        end
        chk(name, {31'd0, got}, 32'd1);
    endtask

    // Quiet level change: modes off while the new level settles through.
    task automatic setup(input logic [3:0] sig, input logic [7:0] mode);
        i_mode = 8'h00;
        tick(1);
        i_signal = sig;
        tick(6);
        i_mode = mode;
        tick(2);
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        sb.delete();
        tick(2);
        i_reset = 1'b1;
        tick(8);
    endtask

    // Every accepted event must match the oldest expectation.
    always @(negedge i_clk) begin
        if (i_reset === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                errors++;
                $display("FAIL unexpected_event: got channel %0d edge %0d, required none",
                         o_channel, o_edge);
            end else begin
                ev_t ev;
                ev = sb.pop_front();
                chk("ev_channel", {30'd0, o_channel}, {30'd0, ev.ch});
                chk("ev_edge", {31'd0, o_edge}, {31'd0, ev.edg});
            end
        end
    end

    initial begin
        vecs[0] = '{ch: 0, mode: 2'b01, en: 1'b1, lvl: 1'b1, exp_evt: 1'b1};
        vecs[1] = '{ch: 0, mode: 2'b01, en: 1'b1, lvl: 1'b0, exp_evt: 1'b0};
        vecs[2] = '{ch: 1, mode: 2'b10, en: 1'b1, lvl: 1'b1, exp_evt: 1'b0};
        vecs[3] = '{ch: 1, mode: 2'b10, en: 1'b1, lvl: 1'b0, exp_evt: 1'b1};
        vecs[4] = '{ch: 2, mode: 2'b11, en: 1'b1, lvl: 1'b1, exp_evt: 1'b1};
        vecs[5] = '{ch: 2, mode: 2'b11, en: 1'b1, lvl: 1'b0, exp_evt: 1'b1};
        vecs[6] = '{ch: 3, mode: 2'b00, en: 1'b1, lvl: 1'b1, exp_evt: 1'b0};
        vecs[7] = '{ch: 3, mode: 2'b01, en: 1'b0, lvl: 1'b1, exp_evt: 1'b0};

        i_reset       = 1'b0;
        i_signal      = 4'b1111;
        i_enable      = 4'hF;
        i_mode        = 8'hFF;
        i_ready       = 1'b1;
        i_overrun_clr = 1'b0;

        // Reset values, then static-high inputs through release.
        repeat (2) @(negedge i_clk);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_channel", {30'd0, o_channel}, 32'd0);
        chk("rst_edge", {31'd0, o_edge}, 32'd0);
        chk("rst_pending", {28'd0, o_pending}, 32'd0);
        chk("rst_overrun", {28'd0, o_overrun}, 32'd0);
        tick(1);
        i_reset = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(negedge i_clk);
            if (o_valid) seen = 1'b1;
        end
        chk("warmup_no_event", {31'd0, seen}, 32'd0);
        chk("warmup_pending", {28'd0, o_pending}, 32'd0);

        // Single-channel mode/enable vectors.
        tick(1);
        for (int v = 0; v < 8; v++) begin
            i_mode = 8'h00;
            tick(1);
            i_signal[vecs[v].ch] = ~vecs[v].lvl;
            tick(6);
            i_mode[2*vecs[v].ch +: 2] = vecs[v].mode;
            i_enable[vecs[v].ch]      = vecs[v].en;
            tick(2);
            i_signal[vecs[v].ch] = vecs[v].lvl;
            if (vecs[v].exp_evt) push_ev(vecs[v].ch, vecs[v].lvl);
            tick(8);
            chk($sformatf("vec%0d_drained", v), sb.size(), 32'd0);
            i_enable = 4'hF;
        end

        // Latency: ch2 rise sampled at t0 presents at t0+4 for one cycle.
        setup(4'b0000, 8'hDF);
        i_signal[2] = 1'b1;
        push_ev(2, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            chk($sformatf("latency_valid_t%0d", k), {31'd0, o_valid}, {31'd0, (k == 4)});
        end
        tick(1);
        i_signal[2] = 1'b0;
        tick(8);
        chk("pos_fall_ignored", sb.size(), 32'd0);

        // Round robin from a fresh pointer, then wrap.
        setup(4'b0000, 8'hFF);
        do_reset();
        i_ready  = 1'b0;
        i_signal = 4'b1011;
        push_ev(0, 1'b1);
        push_ev(1, 1'b1);
        push_ev(3, 1'b1);
        wait_valid("rr_wait");
        tick(2);
        chk("rr_hold_channel", {30'd0, o_channel}, 32'd0);
        chk("rr_hold_pending", {28'd0, o_pending}, 32'b1010);
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk($sformatf("b2b_valid%0d", k), {31'd0, o_valid}, {31'd0, (k < 3)});
        end
        tick(1);
        i_ready  = 1'b0;
        i_signal = 4'b0010;
        push_ev(0, 1'b0);
        push_ev(3, 1'b0);
        wait_valid("wrap_wait");
        tick(2);
        chk("wrap_channel", {30'd0, o_channel}, 32'd0);
        chk("wrap_pending", {28'd0, o_pending}, 32'b1000);
        i_ready = 1'b1;
        tick(4);
        chk("wrap_drained", sb.size(), 32'd0);

        // Overrun: ch1 keeps its first (rising) event while ch0 holds the slot.
        setup(4'b0000, 8'hFF);
        i_ready     = 1'b0;
        i_signal[0] = 1'b1;
        push_ev(0, 1'b1);
        wait_valid("ovr_wait");
        tick(1);
        i_signal[1] = 1'b1;
        push_ev(1, 1'b1);
        tick(3);
        i_signal[1] = 1'b0;
        tick(3);
        i_signal[1] = 1'b1;
        tick(6);
        chk("ovr_flag", {28'd0, o_overrun}, 32'b0010);
        chk("ovr_pending", {28'd0, o_pending}, 32'b0010);
        chk("ovr_hold_channel", {30'd0, o_channel}, 32'd0);
        i_ready = 1'b1;
        tick(6);
        chk("ovr_drained", sb.size(), 32'd0);
        tick(1);
        i_overrun_clr = 1'b1;
        tick(1);
        i_overrun_clr = 1'b0;
        chk("ovr_cleared", {28'd0, o_overrun}, 32'd0);

        // NEG mode on ch0, then disable a re-pended ch0.
        setup(4'b0011, 8'hFE);
        i_signal[0] = 1'b0;
        push_ev(0, 1'b0);
        tick(8);
        chk("neg_fall_event", sb.size(), 32'd0);
        i_signal[0] = 1'b1;
        tick(8);
        chk("neg_rise_ignored", sb.size(), 32'd0);
        i_ready     = 1'b0;
        i_signal[1] = 1'b0;
        push_ev(1, 1'b0);
        wait_valid("dis_wait");
        tick(1);
        i_signal[0] = 1'b0;
        tick(6);
        chk("dis_pend_set", {28'd0, o_pending}, 32'b0001);
        chk("dis_hold_channel", {30'd0, o_channel}, 32'd1);
        i_enable = 4'b1110;
        tick(2);
        chk("dis_pend_clear", {28'd0, o_pending}, 32'd0);
        i_ready = 1'b1;
        tick(6);
        chk("dis_drained", sb.size(), 32'd0);
        i_enable = 4'hF;

        // Asynchronous reset while an event is held.
        setup(4'b0000, 8'hFF);
        i_ready     = 1'b0;
        i_signal[0] = 1'b1;
        push_ev(0, 1'b1);
        wait_valid("mid_wait");
        tick(1);
        i_signal[2] = 1'b1;
        push_ev(2, 1'b1);
        tick(6);
        i_signal[2] = 1'b0;
        tick(6);
        i_ready = 1'b1;
        tick(1);
        i_ready     = 1'b0;
        i_signal[1] = 1'b1;
        i_signal[3] = 1'b1;
        push_ev(1, 1'b1);
        push_ev(3, 1'b1);
        tick(6);
        chk("mid_valid", {31'd0, o_valid}, 32'd1);
        chk("mid_channel", {30'd0, o_channel}, 32'd2);
        chk("mid_pending", {28'd0, o_pending}, 32'b1010);
        chk("mid_overrun", {28'd0, o_overrun}, 32'b0100);
        #3;
        i_reset = 1'b0;
        #1;
        chk("async_valid", {31'd0, o_valid}, 32'd0);
        chk("async_channel", {30'd0, o_channel}, 32'd0);
        chk("async_edge", {31'd0, o_edge}, 32'd0);
        chk("async_pending", {28'd0, o_pending}, 32'd0);
        chk("async_overrun", {28'd0, o_overrun}, 32'd0);
        sb.delete();
        tick(2);
        i_reset = 1'b1;
        i_ready = 1'b1;
        seen    = 1'b0;
        repeat (30) begin
            @(negedge i_clk);
            if (o_valid) seen = 1'b1;
        end
        chk("post_reset_no_event", {31'd0, seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
